// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and EX-operand forwarding control for a 5-stage pipeline.
// Define HAZARD_CTRL_FWD_EN to enable forwarding (then only load-use stalls remain).
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_rd,
    input  logic [6:0]  id_ctrl,
    input  logic        branch_taken,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_count
);

    logic [4:0]  ex_dst_q, ex_rs_q, ex_rt_q;
    logic        ex_regw_q, ex_memr_q;
    logic [4:0]  mem_dst_q;
    logic        mem_regw_q, mem_memr_q;
    logic [4:0]  wb_dst_q;
    logic        wb_regw_q;
    logic [4:0]  ex_dst_d;
    logic        ex_regw_d, ex_memr_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
    logic        stall;
    logic        unused_ok;

    function automatic logic match(input logic regw, input logic [4:0] dst,
                                   input logic [4:0] r);
        return regw && (dst != 5'd0) && (dst == r);
    endfunction

    assign ex_rs_hit  = match(ex_regw_q, ex_dst_q, id_rs);
    assign ex_rt_hit  = id_uses_rt && match(ex_regw_q, ex_dst_q, id_rt);
    assign mem_rs_hit = match(mem_regw_q, mem_dst_q, id_rs);
    assign mem_rt_hit = id_uses_rt && match(mem_regw_q, mem_dst_q, id_rt);

`ifdef HAZARD_CTRL_FWD_EN
    assign stall = id_valid && ex_memr_q && (ex_rs_hit || ex_rt_hit);
`else
    assign stall = id_valid &&
                   (ex_rs_hit || ex_rt_hit || mem_rs_hit || mem_rt_hit);
`endif

    // Reset forces the free-running defaults; a redirect beats a stall.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (rst_n) begin
            if (branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (stall) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    assign ex_dst_d  = id_ctrl[5] ? id_rd : id_rt;
    assign ex_regw_d = id_ctrl[4] & id_valid & ~idex_bubble;
    assign ex_memr_d = id_ctrl[2] & id_valid & ~idex_bubble;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && !branch_taken && stall_count_q != 16'hFFFF)
            stall_count_d = stall_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_dst_q      <= 5'd0;
            ex_rs_q       <= 5'd0;
            ex_rt_q       <= 5'd0;
            ex_regw_q     <= 1'b0;
            ex_memr_q     <= 1'b0;
            mem_dst_q     <= 5'd0;
            mem_regw_q    <= 1'b0;
            mem_memr_q    <= 1'b0;
            wb_dst_q      <= 5'd0;
            wb_regw_q     <= 1'b0;
            stall_count_q <= 16'd0;
        end else begin
            ex_dst_q      <= ex_dst_d;
            ex_rs_q       <= id_rs;
            ex_rt_q       <= id_rt;
            ex_regw_q     <= ex_regw_d;
            ex_memr_q     <= ex_memr_d;
            mem_dst_q     <= ex_dst_q;
            mem_regw_q    <= ex_regw_q;
            mem_memr_q    <= ex_memr_q;
            wb_dst_q      <= mem_dst_q;
            wb_regw_q     <= mem_regw_q;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

`ifdef HAZARD_CTRL_FWD_EN
    logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;

    // Computed against the slots the ID instruction will trail by one/two stages.
    always_comb begin
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (!idex_bubble) begin
            if (ex_rs_hit)       fwd_a_d = 2'b10;
            else if (mem_rs_hit) fwd_a_d = 2'b01;
            if (ex_rt_hit)       fwd_b_d = 2'b10;
            else if (mem_rt_hit) fwd_b_d = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;
`else
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    // WB slot and some control bits only document pipeline state.
    assign unused_ok = ^{id_ctrl[6], id_ctrl[3], id_ctrl[1:0], ex_rs_q, ex_rt_q,
                         ex_memr_q, mem_memr_q, wb_dst_q, wb_regw_q};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with a queued scoreboard for hazard_ctrl.
// Expected words are {pc_we, ifid_we, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_count}.
module tb_hazard_ctrl;

    localparam logic [6:0] C_R   = 7'b0110010;
    localparam logic [6:0] C_LW  = 7'b1010100;
    localparam logic [6:0] C_NOP = 7'b0000000;

    typedef struct {
        int          id;
        logic [23:0] v;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic [4:0]  id_rd;
    logic [6:0]  id_ctrl;
    logic        branch_taken;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_bubble;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_count;

    exp_t        sb[$];
    exp_t        cur;
    logic [23:0] act;
    int          n_vec = 0;
    int          n_bad = 0;
    int          step_no = 0;

    hazard_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_rd        (id_rd),
        .id_ctrl      (id_ctrl),
        .branch_taken (branch_taken),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] mk(input logic p, input logic f,
                                       input logic fl, input logic b,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic [15:0] sc);
        return {p, f, fl, b, fa, fb, sc};
    endfunction

    // Drive one cycle of inputs just after a rising edge; queue its expectation.
    task automatic step(input logic r, input logic v,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic u, input logic [4:0] rd,
                        input logic [6:0] c, input logic br,
                        input logic chk, input logic [23:0] e);
        exp_t x;
        rst_n        = r;
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = u;
        id_rd        = rd;
        id_ctrl      = c;
        branch_taken = br;
        if (chk) begin
            x.id = step_no;
            x.v  = e;
            sb.push_back(x);
        end
        step_no++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            act = {pc_we, ifid_we, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_count};
            n_vec++;
            if (act !== cur.v) begin
                n_bad++;
                $display("FAIL vec%0d: got pc/ifid/flush/bub=%b fwd_a=%b fwd_b=%b cnt=%h, want pc/ifid/flush/bub=%b fwd_a=%b fwd_b=%b cnt=%h",
                         cur.id, act[23:20], act[19:18], act[17:16], act[15:0],
                         cur.v[23:20], cur.v[19:18], cur.v[17:16], cur.v[15:0]);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: run exceeded time limit, %0d expectations pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        id_valid     = 1'b0;
        id_rs        = 5'd0;
        id_rt        = 5'd0;
        id_uses_rt   = 1'b0;
        id_rd        = 5'd0;
        id_ctrl      = C_NOP;
        branch_taken = 1'b0;
        @(posedge clk);
        #1;
        // In reset, even a redirect leaves the defaults.
        step(0, 1, 5, 5, 1, 5, C_R, 1, 1, mk(1, 1, 0, 0, 0, 0, 0));
`ifdef HAZARD_CTRL_FWD_EN
        step(1, 1, 1, 2, 0, 0, C_LW,  0, 1, mk(1, 1, 0, 0, 0, 0, 0));
        step(1, 1, 2, 4, 1, 3, C_R,   0, 1, mk(0, 0, 0, 1, 0, 0, 0));
        step(1, 1, 2, 4, 1, 3, C_R,   0, 1, mk(1, 1, 0, 0, 0, 0, 1));
        step(1, 1, 1, 1, 1, 5, C_R,   0, 1, mk(1, 1, 0, 0, 2'b01, 0, 1));
        step(1, 1, 5, 5, 1, 6, C_R,   0, 1, mk(1, 1, 0, 0, 0, 0, 1));
        step(1, 1, 1, 1, 1, 5, C_R,   0, 1, mk(1, 1, 0, 0, 2'b10, 2'b10, 1));
        step(1, 0, 0, 0, 0, 0, C_NOP, 0, 1, mk(1, 1, 0, 0, 0, 0, 1));
        step(1, 1, 5, 5, 1, 6, C_R,   0, 1, mk(1, 1, 0, 0, 0, 0, 1));
        step(1, 1, 1, 1, 1, 0, C_R,   0, 1, mk(1, 1, 0, 0, 2'b01, 2'b01, 1));
        step(1, 1, 0, 0, 1, 7, C_R,   0, 1, mk(1, 1, 0, 0, 0, 0, 1));
        step(1, 1, 1, 8, 0, 0, C_LW,  0, 1, mk(1, 1, 0, 0, 0, 0, 1));
        step(1, 1, 1, 8, 1, 9, C_R,   1, 1, mk(1, 1, 1, 1, 0, 0, 1));
        step(1, 0, 0, 0, 0, 0, C_NOP, 0, 1, mk(1, 1, 0, 0, 0, 0, 1));
        step(1, 1, 1, 2, 0, 0, C_LW,  0, 1, mk(1, 1, 0, 0, 0, 0, 1));
        step(1, 1, 2, 4, 1, 3, C_R,   0, 1, mk(0, 0, 0, 1, 0, 0, 1));
        step(0, 1, 2, 4, 1, 3, C_R,   0, 1, mk(1, 1, 0, 0, 0, 0, 0));
        step(1, 1, 2, 4, 1, 3, C_R,   0, 1, mk(1, 1, 0, 0, 0, 0, 0));
`else
        step(1, 1, 1, 1, 1, 5, C_R,    0, 1, mk(1, 1, 0, 0, 0, 0, 0));
        step(1, 1, 5, 1, 1, 6, C_R,    0, 1, mk(0, 0, 0, 1, 0, 0, 0));
        step(1, 1, 5, 1, 1, 6, C_R,    0, 1, mk(0, 0, 0, 1, 0, 0, 1));
        step(1, 1, 5, 1, 1, 6, C_R,    0, 1, mk(1, 1, 0, 0, 0, 0, 2));
        step(1, 1, 1, 1, 1, 0, C_R,    0, 1, mk(1, 1, 0, 0, 0, 0, 2));
        step(1, 1, 0, 0, 1, 7, C_R,    0, 1, mk(1, 1, 0, 0, 0, 0, 2));
        step(1, 1, 1, 7, 0, 0, C_LW,   0, 1, mk(1, 1, 0, 0, 0, 0, 2));
        step(1, 1, 2, 7, 1, 9, C_R,    0, 1, mk(0, 0, 0, 1, 0, 0, 2));
        step(1, 1, 2, 7, 1, 9, C_R,    1, 1, mk(1, 1, 1, 1, 0, 0, 3));
        step(1, 0, 0, 0, 0, 0, C_NOP,  0, 1, mk(1, 1, 0, 0, 0, 0, 3));
        step(1, 0, 0, 0, 0, 0, C_NOP,  1, 1, mk(1, 1, 1, 1, 0, 0, 3));
        step(1, 1, 1, 1, 1, 10, C_R,   0, 1, mk(1, 1, 0, 0, 0, 0, 3));
        step(1, 1, 10, 10, 1, 11, C_R, 0, 1, mk(0, 0, 0, 1, 0, 0, 3));
        step(1, 1, 10, 10, 1, 11, C_R, 0, 1, mk(0, 0, 0, 1, 0, 0, 4));
        step(0, 1, 10, 10, 1, 11, C_R, 0, 1, mk(1, 1, 0, 0, 0, 0, 0));
        step(1, 1, 10, 10, 1, 11, C_R, 0, 1, mk(1, 1, 0, 0, 0, 0, 0));
        // add $12,$12,$12 held: one issue then two stalls per instance.
        for (int j = 0; j < 98304; j++) begin
            step(1, 1, 12, 12, 1, 12, C_R, 0,
                 (j == 98302) || (j == 98303),
                 (j == 98302) ? mk(0, 0, 0, 1, 0, 0, 16'hFFFE)
                              : mk(0, 0, 0, 1, 0, 0, 16'hFFFF));
        end
        step(1, 1, 12, 12, 1, 12, C_R, 0, 1, mk(1, 1, 0, 0, 0, 0, 16'hFFFF));
`endif
        if (sb.size() != 0) begin
            $display("FAIL scoreboard: %0d expectations never compared, want 0", sb.size());
            n_bad = n_bad + sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
